pipe_stage: RTL and testbench



---
 rtl/pipe_stage_pkg.sv | 39 +++
 rtl/pipe_skid_entry.sv | 45 ++++
 rtl/pipe_stage.sv | 171 +++++++++++++++++
 tb/tb_pipe_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers: control-word
// field map, exception codes and the skid-buffer occupancy encoding.
package pipe_stage_pkg;

  localparam int CTRL_W = 21;
  localparam int EXC_W  = 5;

  // Control-word field positions, decoded by the consuming stage
  localparam int CTRL_DMWR        = 20;
  localparam int CTRL_RFWR        = 19;
  localparam int CTRL_RFRD_HI     = 18;
  localparam int CTRL_RFRD_LO     = 17;
  localparam int CTRL_WASEL_HI    = 16;
  localparam int CTRL_WASEL_LO    = 15;
  localparam int CTRL_WDSEL_HI    = 14;
  localparam int CTRL_WDSEL_LO    = 13;
  localparam int CTRL_EXTOP_HI    = 12;
  localparam int CTRL_EXTOP_LO    = 11;
  localparam int CTRL_PCSRC_HI    = 10;
  localparam int CTRL_PCSRC_LO    = 8;
  localparam int CTRL_ALUSRCA_HI  = 7;
  localparam int CTRL_ALUSRCA_LO  = 6;
  localparam int CTRL_ALUSRCB_HI  = 5;
  localparam int CTRL_ALUSRCB_LO  = 4;
  localparam int CTRL_ALUOP_HI    = 3;
  localparam int CTRL_ALUOP_LO    = 0;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT  = 5'd1;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline slot: a valid flag plus PC/instruction/control/exception payload.
// Clearing zeroes ctrl/exc so an empty slot can never present a live control word.
module pipe_skid_entry #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 21,
  parameter int EXC_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clr,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [CTRL_W-1:0]  d_ctrl,
  input  logic [EXC_W-1:0]   d_exc,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [EXC_W-1:0]   exc
);

  // Slot storage; clear wins over load, pc/instr hold their value on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= {PC_W{1'b0}};
      instr <= {INSTR_W{1'b0}};
      ctrl  <= {CTRL_W{1'b0}};
      exc   <= {EXC_W{1'b0}};
    end else if (clr) begin
      valid <= 1'b0;
      ctrl  <= {CTRL_W{1'b0}};
      exc   <= {EXC_W{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      instr <= d_instr;
      ctrl  <= d_ctrl;
      exc   <= d_exc;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Inter-stage pipeline register built as a 2-entry skid buffer with flush,
// bubble zeroing and first-fault EPC capture.
module pipe_stage #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 21,
  parameter int EXC_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [EXC_W-1:0]   out_exc,
  input  logic               flush,
  output logic [PC_W-1:0]    epc,
  output logic               epc_valid
);
  import pipe_stage_pkg::*;

  occ_state_e         state_r, state_nxt_s;
  logic               in_ready_r;
  logic               accept_s, release_s;
  logic               main_load_s, main_clr_s, main_from_skid_s;
  logic               skid_load_s, skid_clr_s;
  logic [PC_W-1:0]    main_d_pc_s;
  logic [INSTR_W-1:0] main_d_instr_s;
  logic [CTRL_W-1:0]  main_d_ctrl_s;
  logic [EXC_W-1:0]   main_d_exc_s;
  logic               skid_valid_s;
  logic [PC_W-1:0]    skid_pc_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [CTRL_W-1:0]  skid_ctrl_s;
  logic [EXC_W-1:0]   skid_exc_s;
  logic [PC_W-1:0]    epc_r;
  logic               epc_valid_r;

  assign accept_s  = in_valid & in_ready_r;
  assign release_s = out_valid & out_ready;
  assign in_ready  = in_ready_r;
  assign epc       = epc_r;
  assign epc_valid = epc_valid_r;

  // Occupancy next-state and slot load/clear controls; flush overrides everything
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_clr_s  = 1'b1;
      skid_clr_s  = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && release_s) begin
            main_load_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            skid_load_s = 1'b1;
          end else if (release_s) begin
            state_nxt_s = ST_EMPTY;
            main_clr_s  = 1'b1;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (release_s) begin
            state_nxt_s      = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clr_s       = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_clr_s  = 1'b1;
          skid_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // Main slot refills from the skid when draining TWO, otherwise from upstream
  always_comb begin
    main_d_pc_s    = in_pc;
    main_d_instr_s = in_instr;
    main_d_ctrl_s  = in_ctrl;
    main_d_exc_s   = in_exc;
    if (main_from_skid_s) begin
      main_d_pc_s    = skid_pc_s;
      main_d_instr_s = skid_instr_s;
      main_d_ctrl_s  = skid_ctrl_s;
      main_d_exc_s   = skid_exc_s;
    end else begin
      main_d_pc_s    = in_pc;
      main_d_instr_s = in_instr;
      main_d_ctrl_s  = in_ctrl;
      main_d_exc_s   = in_exc;
    end
  end

  // State register; in_ready is registered from the next state to break the ready path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != ST_TWO);
    end
  end

  // First-fault EPC capture; a flush in the same cycle cancels the capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_r       <= {PC_W{1'b0}};
      epc_valid_r <= 1'b0;
    end else if (flush) begin
      epc_valid_r <= 1'b0;
    end else if (release_s && (out_exc != {EXC_W{1'b0}}) && !epc_valid_r) begin
      epc_r       <= out_pc;
      epc_valid_r <= 1'b1;
    end
  end

  pipe_skid_entry #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .EXC_W(EXC_W)
  ) u_main (
    .clk(clk), .rst(rst), .load(main_load_s), .clr(main_clr_s),
    .d_pc(main_d_pc_s), .d_instr(main_d_instr_s),
    .d_ctrl(main_d_ctrl_s), .d_exc(main_d_exc_s),
    .valid(out_valid), .pc(out_pc), .instr(out_instr),
    .ctrl(out_ctrl), .exc(out_exc)
  );

  pipe_skid_entry #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .EXC_W(EXC_W)
  ) u_skid (
    .clk(clk), .rst(rst), .load(skid_load_s), .clr(skid_clr_s),
    .d_pc(in_pc), .d_instr(in_instr), .d_ctrl(in_ctrl), .d_exc(in_exc),
    .valid(skid_valid_s), .pc(skid_pc_s), .instr(skid_instr_s),
    .ctrl(skid_ctrl_s), .exc(skid_exc_s)
  );

  logic unused_s;
  assign unused_s = skid_valid_s;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed vector table, async-reset sequence and a
// randomized run against a queue-based reference model.
module tb_pipe_stage;
  import pipe_stage_pkg::*;

  localparam logic [20:0] CTRL_K  = 21'h15A5A5;
  localparam logic [31:0] INSTR_K = 32'h8C00_0000;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush, epc_valid;
  logic [31:0] in_pc, in_instr, out_pc, out_instr, epc;
  logic [20:0] in_ctrl, out_ctrl;
  logic [4:0]  in_exc, out_exc;

  int checks = 0;
  int errors = 0;

  pipe_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_ctrl(in_ctrl), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_ctrl(out_ctrl), .out_exc(out_exc),
    .flush(flush), .epc(epc), .epc_valid(epc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = 32'h0; in_instr = 32'h0; in_ctrl = 21'h0; in_exc = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] pc, input logic [4:0] exc);
    in_valid = iv; out_ready = ordy; flush = fl;
    in_pc = pc; in_instr = pc ^ INSTR_K; in_ctrl = CTRL_K; in_exc = exc;
  endtask

  typedef struct {
    logic iv, ordy, fl; logic [31:0] pc; logic [4:0] exc;
    logic ov, ir; logic [31:0] opc; logic [4:0] oexc; logic ev; logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr; logic [20:0] ctrl; logic [4:0] exc;
  } beat_t;

  vec_t tbl[15];

  initial begin
    beat_t q[$];
    beat_t shown, b;
    logic m_ir, m_ev, acc, rel, iv, ordy, fl;
    logic [31:0] m_epc;

    //        iv    ordy  fl    pc        exc      ov    ir    out_pc    out_exc  ev    epc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h3000, EXC_NONE, 1'b1, 1'b1, 32'h3000, EXC_NONE, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h3004, EXC_NONE, 1'b1, 1'b1, 32'h3004, EXC_NONE, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h3008, EXC_OV,   1'b1, 1'b1, 32'h3008, EXC_OV,   1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h300C, EXC_NONE, 1'b1, 1'b0, 32'h3008, EXC_OV,   1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h3010, EXC_NONE, 1'b1, 1'b1, 32'h300C, EXC_NONE, 1'b1, 32'h3008};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h3010, EXC_RI,   1'b1, 1'b1, 32'h3010, EXC_RI,   1'b1, 32'h3008};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h3014, EXC_NONE, 1'b0, 1'b1, 32'h3010, EXC_NONE, 1'b1, 32'h3008};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h3020, EXC_NONE, 1'b1, 1'b1, 32'h3020, EXC_NONE, 1'b1, 32'h3008};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h3024, EXC_INT,  1'b1, 1'b0, 32'h3020, EXC_NONE, 1'b1, 32'h3008};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h3028, EXC_NONE, 1'b0, 1'b1, 32'h3020, EXC_NONE, 1'b0, 32'h3008};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,    EXC_NONE, 1'b0, 1'b1, 32'h3020, EXC_NONE, 1'b0, 32'h3008};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h3030, EXC_OV,   1'b1, 1'b1, 32'h3030, EXC_OV,   1'b0, 32'h3008};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h0,    EXC_NONE, 1'b0, 1'b1, 32'h3030, EXC_NONE, 1'b0, 32'h3008};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h3040, EXC_OV,   1'b1, 1'b1, 32'h3040, EXC_OV,   1'b0, 32'h3008};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'h0,    EXC_NONE, 1'b0, 1'b1, 32'h3040, EXC_NONE, 1'b1, 32'h3040};

    do_reset();
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_in_ready",  {31'h0, in_ready},  32'h1);
    chk("reset_out_pc",    out_pc,             32'h0);
    chk("reset_out_instr", out_instr,          32'h0);
    chk("reset_out_ctrl",  {11'h0, out_ctrl},  32'h0);
    chk("reset_out_exc",   {27'h0, out_exc},   32'h0);
    chk("reset_epc",       epc,                32'h0);
    chk("reset_epc_valid", {31'h0, epc_valid}, 32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pc, tbl[i].exc);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'h0, in_ready},  {31'h0, tbl[i].ir});
      chk($sformatf("vec%0d_out_pc", i),    out_pc,             tbl[i].opc);
      chk($sformatf("vec%0d_out_instr", i), out_instr,          tbl[i].opc ^ INSTR_K);
      chk($sformatf("vec%0d_out_ctrl", i),  {11'h0, out_ctrl},  tbl[i].ov ? {11'h0, CTRL_K} : 32'h0);
      chk($sformatf("vec%0d_out_exc", i),   {27'h0, out_exc},   {27'h0, tbl[i].oexc});
      chk($sformatf("vec%0d_epc_valid", i), {31'h0, epc_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("vec%0d_epc", i),       epc,                tbl[i].epc);
    end

    // Fill both slots with a captured EPC, then hit rst between clock edges
    drive(1'b1, 1'b1, 1'b0, 32'h3050, EXC_OV);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h3054, EXC_NONE);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h3058, EXC_NONE);
    @(negedge clk);
    chk("pre_rst_in_ready",  {31'h0, in_ready},  32'h0);
    chk("pre_rst_epc_valid", {31'h0, epc_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_in_ready",  {31'h0, in_ready},  32'h1);
    chk("async_rst_out_pc",    out_pc,             32'h0);
    chk("async_rst_out_ctrl",  {11'h0, out_ctrl},  32'h0);
    chk("async_rst_epc",       epc,                32'h0);
    chk("async_rst_epc_valid", {31'h0, epc_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_skid_gone", {31'h0, out_valid}, 32'h0);

    // Randomized run against a FIFO-of-beats model with capacity two
    do_reset();
    q.delete();
    shown = '{32'h0, 32'h0, 21'h0, 5'd0};
    m_ir = 1'b1; m_ev = 1'b0; m_epc = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      b.pc    = $urandom & 32'hFFFF_FFFC;
      b.instr = $urandom;
      b.ctrl  = 21'($urandom);
      case ($urandom_range(0, 9))
        0:       b.exc = EXC_OV;
        1:       b.exc = EXC_RI;
        default: b.exc = EXC_NONE;
      endcase
      in_valid = iv; out_ready = ordy; flush = fl;
      in_pc = b.pc; in_instr = b.instr; in_ctrl = b.ctrl; in_exc = b.exc;
      @(negedge clk);
      acc = iv && m_ir;
      rel = (q.size() > 0) && ordy;
      if (fl) begin
        q.delete();
        m_ev = 1'b0;
      end else begin
        if (rel) begin
          if (q[0].exc != 5'd0 && !m_ev) begin
            m_epc = q[0].pc;
            m_ev  = 1'b1;
          end
          void'(q.pop_front());
        end
        if (acc) q.push_back(b);
      end
      m_ir = (q.size() < 2);
      if (q.size() > 0) shown = q[0];
      chk("rand_out_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
      chk("rand_in_ready",  {31'h0, in_ready},  {31'h0, m_ir});
      chk("rand_out_pc",    out_pc,             shown.pc);
      chk("rand_out_instr", out_instr,          shown.instr);
      chk("rand_out_ctrl",  {11'h0, out_ctrl},  (q.size() > 0) ? {11'h0, shown.ctrl} : 32'h0);
      chk("rand_out_exc",   {27'h0, out_exc},   (q.size() > 0) ? {27'h0, shown.exc} : 32'h0);
      chk("rand_epc_valid", {31'h0, epc_valid}, {31'h0, m_ev});
      chk("rand_epc",       epc,                m_epc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
